// File: rtl/fpmult_iter_radix.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_iter_radix
// Brief    : Iterative Qm.d fixed-point multiplier, K multiplier bits per cycle,
//            signed/unsigned, round/truncate, saturating, val/rdy interfaces.
// Revision : 1.0
// ============================================================================
module fpmult_iter_radix #(
    parameter int n = 32,
    parameter int d = 16,
    parameter int K = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recv_val,
    output logic             recv_rdy,
    input  logic [2*n-1:0]   recv_msg,
    input  logic [1:0]       recv_mode,
    output logic             send_val,
    input  logic             send_rdy,
    output logic [n-1:0]     send_msg,
    output logic             send_ovf
);

    localparam int BEATS = n / K;
    localparam int CW    = $clog2(BEATS) + 1;

    localparam logic [2*n:0] HALF = (d > 0) ? ((2*n+1)'(1) << (d - 1)) : '0;
    localparam logic [2*n:0] SMAX = {{(n+2){1'b0}}, {(n-1){1'b1}}};
    localparam logic [2*n:0] SMIN = SMAX + (2*n+1)'(1);
    localparam logic [2*n:0] UMAX = {{(n+1){1'b0}}, {n{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic              signed_q;
    logic              round_q;
    logic              sign_q;
    logic [2*n-1:0]    a_sh_q;
    logic [n-1:0]      b_q;
    logic [2*n-1:0]    p_q;
    logic [CW-1:0]     cnt_q;
    logic              send_val_q;
    logic [n-1:0]      send_msg_q;
    logic              send_ovf_q;

    logic [n-1:0]      a_raw;
    logic [n-1:0]      b_raw;
    logic [n-1:0]      a_mag;
    logic [n-1:0]      b_mag;
    logic [2*n-1:0]    pp;
    logic [2*n-1:0]    p_d;
    logic [2*n:0]      r;
    logic [2*n:0]      q;
    logic [n-1:0]      c_d;
    logic              ovf_d;

    always_comb begin
        a_raw = recv_msg[2*n-1:n];
        b_raw = recv_msg[n-1:0];
        a_mag = (recv_mode[0] && a_raw[n-1]) ? -a_raw : a_raw;
        b_mag = (recv_mode[0] && b_raw[n-1]) ? -b_raw : b_raw;

        // One radix-2^K beat: shifted multiplicand selected by each of the K low multiplier bits.
        pp = '0;
        for (int j = 0; j < K; j++) begin
            if (b_q[j]) begin
                pp = pp + (a_sh_q << j);
            end
        end
        p_d = p_q + pp;

        r = {1'b0, p_q} + (round_q ? HALF : '0);
        q = r >> d;

        ovf_d = 1'b0;
        c_d   = q[n-1:0];
        if (signed_q) begin
            if (!sign_q && (q > SMAX)) begin
                c_d   = {1'b0, {(n-1){1'b1}}};
                ovf_d = 1'b1;
            end else if (sign_q && (q > SMIN)) begin
                c_d   = {1'b1, {(n-1){1'b0}}};
                ovf_d = 1'b1;
            end else if (sign_q) begin
                c_d = -q[n-1:0];
            end
        end else if (q > UMAX) begin
            c_d   = {n{1'b1}};
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            signed_q   <= 1'b0;
            round_q    <= 1'b0;
            sign_q     <= 1'b0;
            a_sh_q     <= '0;
            b_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            send_val_q <= 1'b0;
            send_msg_q <= '0;
            send_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (recv_val) begin
                        signed_q <= recv_mode[0];
                        round_q  <= recv_mode[1];
                        sign_q   <= recv_mode[0] & (a_raw[n-1] ^ b_raw[n-1]);
                        a_sh_q   <= {{n{1'b0}}, a_mag};
                        b_q      <= b_mag;
                        p_q      <= '0;
                        cnt_q    <= '0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    p_q    <= p_d;
                    a_sh_q <= a_sh_q << K;
                    b_q    <= b_q >> K;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(BEATS - 1)) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    send_msg_q <= c_d;
                    send_ovf_q <= ovf_d;
                    send_val_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (send_rdy) begin
                        send_val_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    send_val_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign recv_rdy = reset & (state_q == IDLE);
    assign send_val = send_val_q;
    assign send_msg = send_msg_q;
    assign send_ovf = send_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fpmult_iter_radix.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpmult_iter_radix
// Brief    : Scoreboard bench for fpmult_iter_radix, K=1 and K=4 side by side.
// Revision : 1.0
// ============================================================================
module tb_fpmult_iter_radix;

    localparam int N = 32;
    localparam int D = 16;

    typedef struct {
        logic [31:0] msg;
        logic        ovf;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          recv_val;
    logic [63:0]   recv_msg;
    logic [1:0]    recv_mode;
    logic          send_rdy;
    logic          rr [2];
    logic          sv [2];
    logic [31:0]   sm [2];
    logic          so [2];

    exp_t          expq [2][$];
    bit            seen [2];
    int            lat  [2] = '{N / 1 + 1, N / 4 + 1};
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpmult_iter_radix #(.n(N), .d(D), .K(1)) u_dut1 (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rr[0]),
        .recv_msg(recv_msg), .recv_mode(recv_mode), .send_val(sv[0]),
        .send_rdy(send_rdy), .send_msg(sm[0]), .send_ovf(so[0])
    );

    fpmult_iter_radix #(.n(N), .d(D), .K(4)) u_dut4 (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rr[1]),
        .recv_msg(recv_msg), .recv_mode(recv_mode), .send_val(sv[1]),
        .send_rdy(send_rdy), .send_msg(sm[1]), .send_ovf(so[1])
    );

    // Reference: exact product of magnitudes, then round/shift/saturate on the magnitude.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] m, output logic [31:0] c, output logic o);
        logic [31:0] ma, mb;
        logic [64:0] q;
        logic        neg;
        ma  = (m[0] && a[31]) ? 32'(-a) : a;
        mb  = (m[0] && b[31]) ? 32'(-b) : b;
        q   = (65'(ma) * 65'(mb) + (m[1] ? (65'd1 << (D - 1)) : 65'd0)) >> D;
        neg = m[0] & (a[31] ^ b[31]);
        o   = 1'b0;
        c   = q[31:0];
        if (m[0]) begin
            if (!neg && q > 65'h7FFF_FFFF) begin
                c = 32'h7FFF_FFFF; o = 1'b1;
            end else if (neg && q > 65'h8000_0000) begin
                c = 32'h8000_0000; o = 1'b1;
            end else if (neg) begin
                c = -c;
            end
        end else if (q > 65'hFFFF_FFFF) begin
            c = 32'hFFFF_FFFF; o = 1'b1;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            seen[0] = 1'b0;
            seen[1] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sv[i]) begin
                    check($sformatf("rdy_low_in_done[%0d]", i), 32'(rr[i]), 32'd0);
                    if (expq[i].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result[%0d]: got 0x%08h with no transaction outstanding", i, sm[i]);
                    end else begin
                        if (!seen[i]) begin
                            seen[i] = 1'b1;
                            check($sformatf("latency[%0d]", i), 32'(cyc - expq[i][0].acc), 32'(lat[i]));
                        end
                        check($sformatf("msg[%0d]", i), sm[i], expq[i][0].msg);
                        check($sformatf("ovf[%0d]", i), 32'(so[i]), 32'(expq[i][0].ovf));
                        if (send_rdy) begin
                            void'(expq[i].pop_front());
                            seen[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        int   w;
        exp_t e;
        w = 0;
        while (!(rr[0] && rr[1]) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) begin
            checks++; errors++;
            $display("FAIL issue_timeout: recv_rdy %0b/%0b expected 1/1", rr[0], rr[1]);
        end
        recv_val  = 1'b1;
        recv_msg  = {a, b};
        recv_mode = m;
        @(posedge clk); #1;
        recv_val  = 1'b0;
        recv_msg  = {$urandom, $urandom};
        recv_mode = 2'($urandom_range(0, 3));
        model(a, b, m, e.msg, e.ovf);
        e.acc = cyc;
        expq[0].push_back(e);
        expq[1].push_back(e);
    endtask

    task automatic drain(input bit rand_rdy);
        int w;
        w = 0;
        while ((expq[0].size() != 0 || expq[1].size() != 0) && w < 300) begin
            send_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            w++;
        end
        if (w >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding expected 0", expq[0].size(), expq[1].size());
            expq[0].delete();
            expq[1].delete();
        end
        send_rdy = 1'b1;
    endtask

    logic [31:0] da [9] = '{32'h0001_8000, 32'hFFFE_8000, 32'h0000_0001, 32'h0000_0001,
                            32'hFFFF_FFFF, 32'h7FFF_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] db [9] = '{32'h0002_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_8000,
                            32'h0000_8000, 32'h0002_0000, 32'h0002_0000, 32'h8000_0000, 32'h0001_0000};
    logic [1:0]  dm [9] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01};

    initial begin
        logic [31:0] a, b, held;
        int          t0;
        reset = 1'b0; recv_val = 1'b0; recv_msg = '0; recv_mode = '0; send_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_recv_rdy[%0d]", i), 32'(rr[i]), 32'd0);
            check($sformatf("reset_send_val[%0d]", i), 32'(sv[i]), 32'd0);
            check($sformatf("reset_send_msg[%0d]", i), sm[i], 32'd0);
            check($sformatf("reset_send_ovf[%0d]", i), 32'(so[i]), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("recv_rdy_after_reset", 32'(rr[0] & rr[1]), 32'd1);
        send_rdy = 1'b1;

        for (int i = 0; i < 9; i++) begin
            issue(da[i], db[i], dm[i]);
            drain(1'b0);
        end

        // Hold the consumer off, then release and immediately offer the next operands.
        send_rdy = 1'b0;
        issue(32'h0001_8000, 32'h0002_0000, 2'b00);
        t0 = 0;
        while (!sv[0] && t0 < 100) begin
            @(posedge clk); #1;
            t0++;
        end
        check("bp_send_val", 32'(sv[0]), 32'd1);
        held = sm[0];
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_msg_stable", sm[0], held);
            check("bp_recv_rdy_low", 32'(rr[0]), 32'd0);
        end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_send", 32'(rr[0]), 32'd1);
        t0 = cyc;
        issue(32'hFFFE_8000, 32'hFFFF_0000, 2'b01);
        check("b2b_accept_cycle", 32'(cyc - t0), 32'd1);
        drain(1'b0);

        // Reset mid-CALC (K=1) while the K=4 unit sits in DONE.
        send_rdy = 1'b0;
        issue(32'h0001_8000, 32'h0002_0000, 2'b00);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("midreset_send_val[%0d]", i), 32'(sv[i]), 32'd0);
            check($sformatf("midreset_recv_rdy[%0d]", i), 32'(rr[i]), 32'd0);
            check($sformatf("midreset_send_msg[%0d]", i), sm[i], 32'd0);
        end
        expq[0].delete();
        expq[1].delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(32'h0001_0000, 32'h0001_0000, 2'b00);
        drain(1'b0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) a = 32'($signed(a) >>> $urandom_range(8, 24));
            if ($urandom_range(0, 1) == 1) b = 32'($signed(b) >>> $urandom_range(8, 24));
            issue(a, b, 2'($urandom_range(0, 3)));
            drain(1'b1);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
